// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM encoding, counter
// sizing helper and a word-slice macro.
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A 1-word build still needs a 1-bit counter so the vector is never zero-width.
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

`define MWA_WORD(vec, k, w) vec[(k)*(w) +: (w)]

// File: rtl/multiword_add_sequencer.sv
// Serialises one WIDTH*WORDS-bit addition onto an external WIDTH-bit adder slice,
// LSW first, rippling the carry through a register between words.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*WORDS-1:0]   op_a,
  input  logic [WIDTH*WORDS-1:0]   op_b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*WORDS-1:0]   sum,
  output logic                     cout,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_cout
);

  localparam int N  = WIDTH * WORDS;
  localparam int KW = cnt_w(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            w_last;

  assign w_last    = (r_k == K_LAST);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Slice inputs are held at zero outside RUN so the adder never toggles idly.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (r_state == RUN) begin
      add_a   = `MWA_WORD(r_a, int'(r_k), WIDTH);
      add_b   = `MWA_WORD(r_b, int'(r_k), WIDTH);
      add_cin = r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= cin;
            r_k     <= '0;
          end
        end
        RUN: begin
          `MWA_WORD(r_sum, int'(r_k), WIDTH) <= add_s;
          r_carry <= add_cout;
          if (w_last) begin
            r_cout <= add_cout;
            r_k    <= '0;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: 4-word and 1-word builds, each with a
// behavioural 16-bit adder slice on the add_* ports and a result scoreboard.
module tb_multiword_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-word instance
  logic        in_valid4 = 0, in_ready4, cin4 = 0, out_valid4, out_ready4 = 1, cout4;
  logic [63:0] op_a4 = '0, op_b4 = '0, sum4;
  logic [15:0] a4_a, a4_b, a4_s;
  logic        a4_cin, a4_co;
  assign {a4_co, a4_s} = {1'b0, a4_a} + {1'b0, a4_b} + {16'b0, a4_cin};

  multiword_add_sequencer #(.WIDTH(16), .WORDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .cin(cin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .add_a(a4_a),
    .add_b(a4_b), .add_cin(a4_cin), .add_s(a4_s), .add_cout(a4_co));

  // 1-word instance
  logic        in_valid1 = 0, in_ready1, cin1 = 0, out_valid1, out_ready1 = 1, cout1;
  logic [15:0] op_a1 = '0, op_b1 = '0, sum1;
  logic [15:0] a1_a, a1_b, a1_s;
  logic        a1_cin, a1_co;
  assign {a1_co, a1_s} = {1'b0, a1_a} + {1'b0, a1_b} + {16'b0, a1_cin};

  multiword_add_sequencer #(.WIDTH(16), .WORDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .cin(cin1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .cout(cout1), .add_a(a1_a),
    .add_b(a1_b), .add_cin(a1_cin), .add_s(a1_s), .add_cout(a1_co));

  logic [64:0] q4[$];
  logic [16:0] q1[$];

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Scoreboards: compare every retired result against the queued model value.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4.size() == 0) chk("sb4_unexpected_result", 65'd1, 65'd0);
      else chk("sb4_result", {cout4, sum4}, q4.pop_front());
    end
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("sb1_unexpected_result", 65'd1, 65'd0);
      else chk("sb1_result", {48'b0, cout1, sum1}, {48'b0, q1.pop_front()});
    end
  end

  task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic c,
                     input logic [64:0] exp, input bit hold);
    int lat;
    chk("in_ready_before_op", {64'b0, in_ready4}, 65'd1);
    in_valid4 = 1; op_a4 = a; op_b4 = b; cin4 = c;
    q4.push_back(exp);
    @(posedge clk); #1;
    in_valid4 = 0; op_a4 = {$urandom, $urandom}; op_b4 = {$urandom, $urandom};
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency4", 65'(lat), 65'd4);
    chk("slice_idle_in_done", {47'b0, a4_a, a4_b, a4_cin}, 65'd0);
    if (!hold) begin
      @(posedge clk); #1;
      chk("in_ready_after_retire", {64'b0, in_ready4}, 65'd1);
      chk("out_valid_after_retire", {64'b0, out_valid4}, 65'd0);
    end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] s;
    logic        co;
  } vec_t;

  initial begin
    vec_t tv[7];
    logic [64:0] snap;
    logic [63:0] ra, rb;
    logic        rc;
    int bad;
    int lat;

    tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    tv[1] = '{64'd55000, 64'd7000, 1'b1, 64'd62001, 1'b0};
    tv[2] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    tv[3] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    tv[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    tv[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    tv[6] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};

    #3;
    chk("reset_in_ready", {64'b0, in_ready4}, 65'd1);
    chk("reset_out_valid", {64'b0, out_valid4}, 65'd0);
    chk("reset_sum_cout", {cout4, sum4}, 65'd0);
    chk("reset_slice_inputs", {47'b0, a4_a, a4_b, a4_cin}, 65'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) op4(tv[i].a, tv[i].b, tv[i].c, {tv[i].co, tv[i].s}, 0);

    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
      op4(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {64'b0, rc}, 0);
    end

    // Back-pressure: result held, new request ignored while DONE.
    out_ready4 = 0;
    op4(64'd55000, 64'd7000, 1'b1, {1'b0, 64'd62001}, 1);
    snap = {cout4, sum4};
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({cout4, sum4} !== snap || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) bad++;
      if (i == 3) begin in_valid4 = 1; op_a4 = 64'd1; op_b4 = 64'd1; end
      else in_valid4 = 0;
    end
    chk("hold_stable", 65'(bad), 65'd0);
    out_ready4 = 1;
    @(posedge clk); #1;
    chk("hold_retire_in_ready", {64'b0, in_ready4}, 65'd1);
    chk("hold_retire_out_valid", {64'b0, out_valid4}, 65'd0);

    // Reset two cycles into RUN aborts the operation.
    in_valid4 = 1; op_a4 = 64'h1234_5678_9ABC_DEF0; op_b4 = 64'h1; cin4 = 0;
    @(posedge clk); #1;
    in_valid4 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("abort_in_ready", {64'b0, in_ready4}, 65'd1);
    chk("abort_out_valid", {64'b0, out_valid4}, 65'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid4 !== 1'b0) bad++;
    end
    chk("abort_no_out_valid", 65'(bad), 65'd0);
    op4(64'd999, 64'd0, 1'b1, {1'b0, 64'd1000}, 0);

    // Single-word build.
    in_valid1 = 1; op_a1 = 16'hFFFF; op_b1 = 16'h0; cin1 = 1;
    q1.push_back({1'b1, 16'h0000});
    @(posedge clk); #1;
    in_valid1 = 0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency1", 65'(lat), 65'd1);
    @(posedge clk); #1;
    chk("w1_in_ready_after_retire", {64'b0, in_ready1}, 65'd1);
    in_valid1 = 1; op_a1 = 16'h1234; op_b1 = 16'h0FF0; cin1 = 0;
    q1.push_back({1'b0, 16'h2224});
    @(posedge clk); #1;
    in_valid1 = 0;
    repeat (3) begin @(posedge clk); #1; end

    chk("q4_drained", 65'(q4.size()), 65'd0);
    chk("q1_drained", 65'(q1.size()), 65'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
